// File: rtl/serializer_load_sched_if.sv
// Requester handshake and serializer-side bus of serializer_load_sched.
// slave is the scheduler's view; master is the view of whoever drives the requests.
interface serializer_load_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       req_valid_i;
  logic [NUM_REQ*WIDTH-1:0] req_data_i;
  logic [NUM_REQ-1:0]       req_ready_o;
  logic [WIDTH-1:0]         word_o;
  logic                     load_o;
  logic                     idle_o;
  logic [IDW-1:0]           grant_id_o;

  modport slave (
    input  req_valid_i, req_data_i,
    output req_ready_o, word_o, load_o, idle_o, grant_id_o
  );

  modport master (
    output req_valid_i, req_data_i,
    input  req_ready_o, word_o, load_o, idle_o, grant_id_o
  );
endinterface

// File: rtl/serializer_load_sched.sv
// Slot scheduler feeding the tree serializer: round-robin grant once per LOAD_DIV cycles.
// Optional macro SCHED_STATS_EN adds saturating slot/idle counters.
module serializer_load_sched #(
  parameter int               NUM_REQ   = 4,
  parameter int               WIDTH     = 16,
  parameter int               LOAD_DIV  = 8,
  parameter logic [WIDTH-1:0] IDLE_WORD = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   div_rst_i,
  input  logic                   en_i,
  serializer_load_sched_if.slave bus
`ifdef SCHED_STATS_EN
  ,
  output logic [15:0]            slot_cnt_o,
  output logic [15:0]            idle_cnt_o
`endif
);

  localparam int PW  = (LOAD_DIV > 2) ? $clog2(LOAD_DIV) : 1;
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PW-1:0] LAST = PW'(LOAD_DIV - 1);

  typedef enum logic [1:0] {
    S_HOLD,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [PW-1:0]       r_phase, w_phase_nxt;
  logic [IDW-1:0]      r_ptr;
  logic [WIDTH-1:0]    r_word;
  logic                r_load;
  logic                r_idle;
  logic [IDW-1:0]      r_gid;

  logic                w_active;
  logic                w_slot;
  logic                w_found;
  logic [IDW-1:0]      w_gnt_id;
  logic [IDW-1:0]      w_idx;
  logic [NUM_REQ-1:0]  w_ready;
  logic [WIDTH-1:0]    w_gnt_data;

  // div_rst_i low forces HOLD in the same cycle, so it gates the slot directly.
  assign w_active = (r_state != S_HOLD) && div_rst_i;
  assign w_slot   = w_active && (r_phase == LAST);

  always_comb begin
    w_found  = 1'b0;
    w_gnt_id = '0;
    w_idx    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_idx = IDW'((32'(r_ptr) + i) % NUM_REQ);
      if (!w_found && bus.req_valid_i[w_idx]) begin
        w_found  = 1'b1;
        w_gnt_id = w_idx;
      end
    end
  end

  always_comb begin
    w_ready = '0;
    if (w_slot && w_found) begin
      w_ready[w_gnt_id] = 1'b1;
    end
  end

  assign w_gnt_data = bus.req_data_i[32'(w_gnt_id)*WIDTH +: WIDTH];

  always_comb begin
    w_state_nxt = r_state;
    if (!div_rst_i) begin
      w_state_nxt = S_HOLD;
    end else begin
      case (r_state)
        S_HOLD:  if (en_i) w_state_nxt = S_RUN;
        S_RUN:   if (!en_i) w_state_nxt = w_slot ? S_HOLD : S_DRAIN;
        S_DRAIN: if (w_slot) w_state_nxt = S_HOLD;
        default: w_state_nxt = S_HOLD;
      endcase
    end
  end

  always_comb begin
    w_phase_nxt = '0;
    if (w_active && (r_phase != LAST)) begin
      w_phase_nxt = r_phase + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_HOLD;
      r_phase <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ptr  <= '0;
      r_word <= IDLE_WORD;
      r_load <= 1'b0;
      r_idle <= 1'b0;
      r_gid  <= '0;
    end else if (w_slot) begin
      r_load <= 1'b1;
      if (w_found) begin
        r_word <= w_gnt_data;
        r_idle <= 1'b0;
        r_gid  <= w_gnt_id;
        r_ptr  <= IDW'((32'(w_gnt_id) + 1) % NUM_REQ);
      end else begin
        r_word <= IDLE_WORD;
        r_idle <= 1'b1;
      end
    end else begin
      r_load <= 1'b0;
      r_idle <= 1'b0;
    end
  end

  assign bus.req_ready_o = w_ready;
  assign bus.word_o      = r_word;
  assign bus.load_o      = r_load;
  assign bus.idle_o      = r_idle;
  assign bus.grant_id_o  = r_gid;

`ifdef SCHED_STATS_EN
  logic [15:0] r_slot_cnt;
  logic [15:0] r_idle_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_slot_cnt <= '0;
      r_idle_cnt <= '0;
    end else if (r_load) begin
      if (r_slot_cnt != '1) r_slot_cnt <= r_slot_cnt + 16'd1;
      if (r_idle && (r_idle_cnt != '1)) r_idle_cnt <= r_idle_cnt + 16'd1;
    end
  end

  assign slot_cnt_o = r_slot_cnt;
  assign idle_cnt_o = r_idle_cnt;
`endif

endmodule
